// File: rtl/deb_pkg.sv
// Shared defaults for the switch debouncer: bus width, tick divider,
// acceptance threshold and the per-bit counter width.
package deb_pkg;
    localparam int DEB_WIDTH        = 8;
    localparam int DEB_TICK_DIV     = 10000;
    localparam int DEB_STABLE_TICKS = 8;
    localparam int DEB_CNT_W        = 4;
endpackage

// File: rtl/debounce_bit.sv
// One debounced switch bit: tick-counted acceptance of a new level.
// Edge pulse flops exist only when DEBOUNCE_EDGE_EN is defined.
module debounce_bit
    import deb_pkg::*;
#(
    parameter int STABLE_TICKS = DEB_STABLE_TICKS
) (
    input  logic clk,
    input  logic reset,
    input  logic s2,
    input  logic tick,
    output logic sw_stable,
    output logic sw_rise,
    output logic sw_fall
);

    localparam logic [DEB_CNT_W-1:0] LP_LAST = DEB_CNT_W'(STABLE_TICKS - 1);

    logic [DEB_CNT_W-1:0] r_cnt;
    logic                 r_stable;
    logic                 w_mismatch;
    logic                 w_accept;

    assign w_mismatch = s2 ^ r_stable;
    assign w_accept   = w_mismatch & tick & (r_cnt == LP_LAST);
    assign sw_stable  = r_stable;

    // Any cycle of agreement restarts the count, so bouncing never accumulates
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt    <= {DEB_CNT_W{1'b0}};
            r_stable <= 1'b0;
        end else if (!w_mismatch) begin
            r_cnt    <= {DEB_CNT_W{1'b0}};
        end else if (w_accept) begin
            r_cnt    <= {DEB_CNT_W{1'b0}};
            r_stable <= s2;
        end else if (tick) begin
            r_cnt    <= r_cnt + DEB_CNT_W'(1);
        end else begin
            r_cnt    <= r_cnt;
        end
    end

`ifdef DEBOUNCE_EDGE_EN
    logic r_rise;
    logic r_fall;

    // Pulses share the acceptance edge, so they coincide with the new level
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_rise <= w_accept & s2;
            r_fall <= w_accept & ~s2;
        end
    end

    assign sw_rise = r_rise;
    assign sw_fall = r_fall;
`else
    assign sw_rise = 1'b0;
    assign sw_fall = 1'b0;
`endif

endmodule

// File: rtl/switch_debounce_sync.sv
// Switch-bus conditioner: 2-flop synchroniser, shared sample prescaler,
// per-bit debounce and a registered settled flag. Edge pulses: DEBOUNCE_EDGE_EN.
module switch_debounce_sync
    import deb_pkg::*;
#(
    parameter int WIDTH        = DEB_WIDTH,
    parameter int TICK_DIV     = DEB_TICK_DIV,
    parameter int STABLE_TICKS = DEB_STABLE_TICKS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_stable,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             settled
);

    localparam int              PRE_W  = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0] LP_TOP = PRE_W'(TICK_DIV - 1);

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;
    logic [PRE_W-1:0] r_pre;
    logic             r_settled;
    logic             w_tick;
    logic [WIDTH-1:0] w_stable;
    logic [WIDTH-1:0] w_match;

    // Plain flop chain; nothing may sit between the two stages
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1 <= {WIDTH{1'b0}};
            r_s2 <= {WIDTH{1'b0}};
        end else begin
            r_s1 <= sw_raw;
            r_s2 <= r_s1;
        end
    end

    // Free-running prescaler shared by all bits
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pre <= {PRE_W{1'b0}};
        end else if (r_pre == LP_TOP) begin
            r_pre <= {PRE_W{1'b0}};
        end else begin
            r_pre <= r_pre + PRE_W'(1);
        end
    end

    assign w_tick = (r_pre == LP_TOP);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            debounce_bit #(
                .STABLE_TICKS (STABLE_TICKS)
            ) u_bit (
                .clk       (clk),
                .reset     (reset),
                .s2        (r_s2[gi]),
                .tick      (w_tick),
                .sw_stable (w_stable[gi]),
                .sw_rise   (sw_rise[gi]),
                .sw_fall   (sw_fall[gi])
            );
        end
    endgenerate

    assign w_match = ~(r_s2 ^ w_stable);

    // Settled flag, one cycle behind the synchronised comparison
    always_ff @(posedge clk) begin
        if (reset) begin
            r_settled <= 1'b1;
        end else begin
            r_settled <= &w_match;
        end
    end

    assign sw_stable = w_stable;
    assign settled   = r_settled;

endmodule
